cc_cond_unit: RTL and testbench
===============================

// Module: cc_cond_unit
// PURPOSE
//   Consumer side of the ALU flag interface. Latches the ALU ZSO flags into the
//   architectural condition-code register when the execute stage requests it.
//   Evaluates the Y86 jump/cmov condition selected by ifun and presents a
//   registered cnd result to the fetch/PC-select and writeback logic.
//   Sits in the execute stage, downstream of alu, under pipeline stall/bubble control.
// PARAMETERS
//   CC_RESET   3'b100  ZSO reset value: Z=1, S=0, O=0
//   IFUN_W     4       width of the ifun condition-select field
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous, active-high reset
//   zso_in     in   3       ALU flags {Z,S,O}: [2]=Z, [1]=S, [0]=O
//   set_cc     in   1       request to write zso_in into the CC register
//   exc_block  in   1       a later stage holds an exception; suppresses any CC write
//   eval_valid in   1       an instruction needing a condition is present
//   ifun       in   IFUN_W  condition select, 0..6
//   stall      in   1       freeze every register this cycle
//   bubble     in   1       squash the current execute-stage instruction
//   cc         out  3       architectural CC register {Z,S,O}
//   cnd        out  1       registered condition result
//   cnd_valid  out  1       cnd corresponds to an accepted evaluation
//   cnd_err    out  1       one-cycle pulse: eval_valid with ifun > 6
// BEHAVIOUR
//   Reset (async, any time, including mid-stall): cc=CC_RESET, cnd=0,
//     cnd_valid=0, cnd_err=0. The first update follows the first clk edge after rst deasserts.
//   Priority per clk edge: bubble > stall > normal.
//   bubble=1:
//     - cnd=0, cnd_valid=0, cnd_err=0.
//     - cc holds; set_cc is ignored for the squashed instruction.
//     - Applies even if stall=1 in the same cycle.
//   stall=1 (bubble=0): cc, cnd, cnd_valid and cnd_err all hold their values.
//   Normal operation:
//     - cc <= zso_in when set_cc && !exc_block; otherwise cc holds.
//     - cnd_valid <= eval_valid.
//     - cnd <= f(ifun, src) when eval_valid; otherwise cnd <= 0.
//     - cnd_err <= eval_valid && ifun > 6.
//   Condition table, with Z,S,O taken from src:
//     0 always 1
//     1 le  (S^O)|Z
//     2 l   S^O
//     3 e   Z
//     4 ne  !Z
//     5 ge  !(S^O)
//     6 g   !(S^O)&!Z
//     7..15 cnd=0 and cnd_err pulses
//   src is the cc register value before this edge (see CONFIGURATION).
//   Latency: one clk from eval_valid to cnd/cnd_valid.
//   Simultaneous set_cc and eval_valid: the evaluation uses the old flags
//     unless the bypass feature is compiled in.
//   exc_block is level-sensitive: it blocks the CC write only, never evaluation.
//   cnd_err is a single-cycle pulse unless held by stall.
// CONFIGURATION
//   CC_BYPASS_EN defined:
//     - src = zso_in when set_cc && !exc_block && !bubble in the same cycle.
//     - Otherwise src = cc.
//     - Allows cmp followed by jXX in the same execute slot.
//   CC_BYPASS_EN undefined:
//     - src = cc always.
//     - The instruction issued after a flag-setting one sees the new flags.
// TESTING
//   1. Reset: rst=1 mid-stall -> cc=3'b100, cnd=0, cnd_valid=0, cnd_err=0 immediately.
//   2. Write: set_cc=1, zso_in=3'b010, then eval ifun=2 next cycle
//        -> cc=3'b010; cnd=1, cnd_valid=1 one clk after eval.
//   3. Blocked write: exc_block=1, set_cc=1, zso_in=3'b001 with cc=3'b100
//        -> cc stays 3'b100; eval ifun=3 gives cnd=1.
//   4. Stall/bubble: stall=1 for 3 cycles with set_cc=1 -> cc and cnd unchanged;
//        then bubble=1 with stall=1 -> cnd_valid=0 and cc unchanged.
//   5. Same-cycle write and eval: cc=3'b100, set_cc=1, zso_in=3'b000, eval ifun=4
//        -> cnd=0 without CC_BYPASS_EN; cnd=1 with CC_BYPASS_EN.
//   6. Sweep and error: all ifun 0..6 over all 8 cc values against the table;
//        ifun=9 -> cnd=0 and cnd_err pulses for exactly one clk.

Source files
------------

// File: rtl/cc_cond_unit.sv
// cc_cond_unit: execute-stage condition-code register and Y86 condition
// evaluator. Latches ALU ZSO flags on request and presents a registered
// jump/cmov condition (cnd) with a valid flag and an error pulse for
// unsupported condition codes.
//
// Optional feature macro: CC_BYPASS_EN
//   defined   : an evaluation in the same cycle as an accepted CC write sees
//               the incoming zso_in flags (cmp + jXX in one execute slot).
//   undefined : evaluation always uses the registered cc value.
module cc_cond_unit #(
    parameter logic [2:0] CC_RESET = 3'b100,
    parameter int         IFUN_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        zso_in,
    input  logic              set_cc,
    input  logic              exc_block,
    input  logic              eval_valid,
    input  logic [IFUN_W-1:0] ifun,
    input  logic              stall,
    input  logic              bubble,
    output logic [2:0]        cc,
    output logic              cnd,
    output logic              cnd_valid,
    output logic              cnd_err
);

    localparam int IFUN_MAX = 6;

    typedef enum logic [2:0] {
        C_ALWAYS = 3'd0,
        C_LE     = 3'd1,
        C_L      = 3'd2,
        C_E      = 3'd3,
        C_NE     = 3'd4,
        C_GE     = 3'd5,
        C_G      = 3'd6
    } cond_e;

    logic       cc_wr;
    logic [2:0] src;
    logic       flag_z;
    logic       flag_s;
    logic       flag_o;
    logic       lt;
    logic       ifun_bad;
    logic       cond_raw;
    logic       cnd_d;
    logic       err_d;
    cond_e      cond_sel;

    // Decide whether the CC register accepts a write and which flags feed the evaluator.
    always_comb begin
        cc_wr = set_cc && !exc_block && !bubble;
`ifdef CC_BYPASS_EN
        src   = cc_wr ? zso_in : cc;
`else
        src   = cc;
`endif
        flag_z = src[2];
        flag_s = src[1];
        flag_o = src[0];
        lt     = flag_s ^ flag_o;
    end

    // Condition evaluation; codes above 6 never assert cnd and raise cnd_err instead.
    always_comb begin
        ifun_bad = (int'(ifun) > IFUN_MAX);
        cond_sel = C_ALWAYS;
        if (!ifun_bad) begin
            cond_sel = cond_e'(ifun[2:0]);
        end
        cond_raw = 1'b0;
        case (cond_sel)
            C_ALWAYS: cond_raw = 1'b1;
            C_LE:     cond_raw = lt | flag_z;
            C_L:      cond_raw = lt;
            C_E:      cond_raw = flag_z;
            C_NE:     cond_raw = !flag_z;
            C_GE:     cond_raw = !lt;
            C_G:      cond_raw = !lt && !flag_z;
            default:  cond_raw = 1'b0;
        endcase
        cnd_d = eval_valid && !ifun_bad && cond_raw;
        err_d = eval_valid && ifun_bad;
    end

    // Register update: bubble squashes the result (even when stalled), stall freezes, otherwise advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc        <= CC_RESET;
            cnd       <= 1'b0;
            cnd_valid <= 1'b0;
            cnd_err   <= 1'b0;
        end else if (bubble) begin
            cnd       <= 1'b0;
            cnd_valid <= 1'b0;
            cnd_err   <= 1'b0;
        end else if (!stall) begin
            if (cc_wr) begin
                cc <= zso_in;
            end
            cnd       <= cnd_d;
            cnd_valid <= eval_valid;
            cnd_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_cc_cond_unit.sv
// tb_cc_cond_unit: directed scenarios plus randomized traffic for
// cc_cond_unit, checked against a behavioural model of the flag register
// and the Y86 condition rules. Honors CC_BYPASS_EN the same way as the design.
module tb_cc_cond_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] zso_in;
    logic       set_cc;
    logic       exc_block;
    logic       eval_valid;
    logic [3:0] ifun;
    logic       stall;
    logic       bubble;
    logic [2:0] cc;
    logic       cnd;
    logic       cnd_valid;
    logic       cnd_err;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit [2:0] m_cc;
    bit       m_cnd;
    bit       m_valid;
    bit       m_err;

`ifdef CC_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    cc_cond_unit #(.CC_RESET(3'b100), .IFUN_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .zso_in     (zso_in),
        .set_cc     (set_cc),
        .exc_block  (exc_block),
        .eval_valid (eval_valid),
        .ifun       (ifun),
        .stall      (stall),
        .bubble     (bubble),
        .cc         (cc),
        .cnd        (cnd),
        .cnd_valid  (cnd_valid),
        .cnd_err    (cnd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Y86 condition semantics from the flag meanings: less = sign differs from overflow.
    function automatic bit y86_cond(input int code, input bit [2:0] flags);
        bit zero = flags[2];
        bit less = (flags[1] != flags[0]);
        case (code)
            0: return 1'b1;
            1: return less || zero;
            2: return less;
            3: return zero;
            4: return !zero;
            5: return !less;
            6: return !less && !zero;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_cc = 3'b100; m_cnd = 0; m_valid = 0; m_err = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".cc"},        {5'd0, cc},        {5'd0, m_cc});
        chk({tag, ".cnd"},       {7'd0, cnd},       {7'd0, m_cnd});
        chk({tag, ".cnd_valid"}, {7'd0, cnd_valid}, {7'd0, m_valid});
        chk({tag, ".cnd_err"},   {7'd0, cnd_err},   {7'd0, m_err});
    endtask

    // One clock: model consumes the inputs present at the edge, outputs sampled 1ns later.
    task automatic tick(input string tag);
        bit       write_ok;
        bit [2:0] flags;
        @(posedge clk);
        write_ok = set_cc && !exc_block && !bubble;
        flags    = (BYPASS && write_ok) ? zso_in : m_cc;
        if (bubble) begin
            m_cnd = 0; m_valid = 0; m_err = 0;
        end else if (!stall) begin
            if (write_ok) m_cc = zso_in;
            m_valid = eval_valid;
            m_err   = eval_valid && (ifun > 6);
            m_cnd   = eval_valid && y86_cond(int'(ifun), flags);
        end
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit sc, input bit [2:0] z, input bit xb,
                         input bit ev, input bit [3:0] f, input bit st, input bit bb);
        set_cc = sc; zso_in = z; exc_block = xb; eval_valid = ev;
        ifun = f; stall = st; bubble = bb;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 3'b000, 0, 0, 4'd0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset.cc", {5'd0, cc}, 8'h04);

        // write flags, then evaluate "l" on them
        drive(1, 3'b010, 0, 0, 4'd0, 0, 0);
        tick("wr");
        chk("wr.cc_const", {5'd0, cc}, 8'h02);
        drive(0, 3'b000, 0, 1, 4'd2, 0, 0);
        tick("wr_eval");
        chk("wr_eval.cnd_const", {7'd0, cnd}, 8'h01);

        // async reset asserted mid-stall, checked without a clock edge
        drive(1, 3'b111, 0, 1, 4'd0, 1, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_mid_stall");
        @(negedge clk) rst = 1'b0;

        // blocked write keeps reset flags; "e" then true
        drive(1, 3'b001, 1, 0, 4'd0, 0, 0);
        tick("blk");
        chk("blk.cc_const", {5'd0, cc}, 8'h04);
        drive(0, 3'b000, 0, 1, 4'd3, 0, 0);
        tick("blk_eval");
        chk("blk_eval.cnd_const", {7'd0, cnd}, 8'h01);

        // stall holds everything for 3 cycles despite set_cc and eval
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'b011, 0, 1, 4'd4, 1, 0);
            tick("stall");
        end
        chk("stall.cnd_held", {7'd0, cnd}, 8'h01);
        drive(1, 3'b011, 0, 1, 4'd0, 1, 1);
        tick("bubble_stall");
        chk("bubble_stall.valid", {7'd0, cnd_valid}, 8'h00);
        chk("bubble_stall.cc", {5'd0, cc}, 8'h04);

        // same-cycle write and "ne" evaluation
        drive(0, 3'b000, 0, 0, 4'd0, 0, 0);
        tick("idle");
        drive(1, 3'b000, 0, 1, 4'd4, 0, 0);
        tick("same_cycle");
        chk("same_cycle.cnd_const", {7'd0, cnd}, BYPASS ? 8'h01 : 8'h00);

        // full sweep of flags x valid conditions
        for (int v = 0; v < 8; v++) begin
            drive(1, 3'(v), 0, 0, 4'd0, 0, 0);
            tick("sweep_wr");
            for (int f = 0; f < 7; f++) begin
                drive(0, 3'b000, 0, 1, 4'(f), 0, 0);
                tick("sweep");
            end
        end

        // unsupported code: cnd 0, error pulse exactly one clock
        drive(0, 3'b000, 0, 1, 4'd9, 0, 0);
        tick("err");
        chk("err.pulse", {7'd0, cnd_err}, 8'h01);
        chk("err.cnd", {7'd0, cnd}, 8'h00);
        drive(0, 3'b000, 0, 0, 4'd0, 0, 0);
        tick("err_end");
        chk("err_end.pulse", {7'd0, cnd_err}, 8'h00);

        // randomized traffic with occasional async resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                #1 rst = 1'b1;
                #1;
                model_reset();
                check_all("rnd_rst");
                rst = 1'b0;
            end
            drive($urandom_range(0, 1), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6)),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
